mux_nor_unit: RTL and testbench

- Bitwise 2-input NOR built from 2:1 multiplexer cells, one mux per bit; no AND/OR/NOT gate primitive produces the NOR.
- Provides a combinational result and a one-cycle registered copy with a valid flag.
- Used as a logic-primitive building block in gate-level datapaths.
- At WIDTH=1 the combinational path is the classic truth table: 00->1, 01->0, 10->0, 11->0.

---
 rtl/mux_nor_unit.sv | 71 +++++++
 tb/tb_mux_nor_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mux_nor_unit.sv
// Bitwise NOR built from one 2:1 mux cell per bit, with a one-cycle registered copy.
// Optional MUX_NOR_REDUCE_EN adds the all-ones reduction nor_all / nor_all_q.
module mux_nor_unit #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
`ifdef MUX_NOR_REDUCE_EN
   output logic             nor_all,
   output logic             nor_all_q,
`endif
   output logic             out_valid
);

   function automatic logic mux2(input logic sel, input logic d1, input logic d0);
      return sel ? d1 : d0;
   endfunction

   logic [WIDTH-1:0] nor_p0;
   logic [WIDTH-1:0] nor_p1;
   logic             vld_p1;

   // stage p0: combinational mux cells, a selects between constant 0 and ~b
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign nor_p0[i] = mux2(a[i], 1'b0, ~b[i]);
   end

   assign out = nor_p0;

`ifdef MUX_NOR_REDUCE_EN
   logic [WIDTH:0] chain_p0;
   logic           all_p1;

   assign chain_p0[0] = 1'b1;
   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      assign chain_p0[i+1] = mux2(nor_p0[i], chain_p0[i], 1'b0);
   end
   assign nor_all = chain_p0[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         all_p1 <= 1'b0;
      end else if (in_valid) begin
         all_p1 <= chain_p0[WIDTH];
      end
   end
   assign nor_all_q = all_p1;
`endif

   // stage p1: capture on in_valid, hold otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nor_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            nor_p1 <= nor_p0;
         end
      end
   end

   assign out_q     = nor_p1;
   assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_nor_unit.sv
// Directed bench for mux_nor_unit: a WIDTH=1 instance for the truth table and a WIDTH=4 instance for the registered path.
module tb_mux_nor_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a1 = 1'b0, b1 = 1'b0, iv1 = 1'b0;
   logic       o1, oq1, ov1;
   logic [3:0] a4 = '0, b4 = '0;
   logic       iv4 = 1'b0;
   logic [3:0] o4, oq4;
   logic       ov4;
`ifdef MUX_NOR_REDUCE_EN
   logic       na1, naq1, na4, naq4;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux_nor_unit #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1),
      .out(o1), .out_q(oq1),
`ifdef MUX_NOR_REDUCE_EN
      .nor_all(na1), .nor_all_q(naq1),
`endif
      .out_valid(ov1)
   );

   mux_nor_unit #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(iv4),
      .out(o4), .out_q(oq4),
`ifdef MUX_NOR_REDUCE_EN
      .nor_all(na4), .nor_all_q(naq4),
`endif
      .out_valid(ov4)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] tt;

   initial begin
      tt = 4'b0001;
      #1;
      chk("reset_out_q", oq4, 4'b0000);
      chk("reset_out_valid", {3'b0, ov4}, 4'b0000);
      chk("reset_out_q_w1", {3'b0, oq1}, 4'b0000);

      // WIDTH=1 truth table: 00->1, 01->0, 10->0, 11->0
      for (int i = 0; i < 4; i++) begin
         {a1, b1} = i[1:0];
         #5;
         chk($sformatf("tt_%0d", i), {3'b0, o1}, {3'b0, tt[i]});
      end

      step();
      rst = 1'b0;

      // single capture
      a4 = 4'b0101; b4 = 4'b0011; iv4 = 1'b1;
      #1;
      chk("comb_0101_0011", o4, 4'b1000);
      step();
      iv4 = 1'b0;
      chk("reg_out_q", oq4, 4'b1000);
      chk("reg_out_valid", {3'b0, ov4}, 4'b0001);
      step();
      chk("reg_valid_drop", {3'b0, ov4}, 4'b0000);
      chk("reg_hold", oq4, 4'b1000);

      // hold: a/b move with in_valid low
      a4 = 4'b0000; b4 = 4'b0000; #1;
      chk("hold_comb_00", o4, 4'b1111);
      a4 = 4'b1111; b4 = 4'b1111; #1;
      chk("hold_comb_FF", o4, 4'b0000);
      a4 = 4'b1010; b4 = 4'b0100; #1;
      chk("hold_comb_A4", o4, 4'b0001);
      step();
      chk("hold_out_q", oq4, 4'b1000);
      chk("hold_out_valid", {3'b0, ov4}, 4'b0000);

      // async reset between edges
      a4 = 4'b0101; b4 = 4'b0011; iv4 = 1'b1;
      step();
      chk("pre_rst_valid", {3'b0, ov4}, 4'b0001);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_q", oq4, 4'b0000);
      chk("async_rst_valid", {3'b0, ov4}, 4'b0000);
      a4 = 4'b0000; b4 = 4'b0000;
      step();
      chk("rst_held_out_q", oq4, 4'b0000);
      chk("rst_held_valid", {3'b0, ov4}, 4'b0000);

      // release reset with in_valid already high
      a4 = 4'b0101; b4 = 4'b0010;
      rst = 1'b0;
      step();
      chk("rel_out_q", oq4, 4'b1000);
      chk("rel_valid", {3'b0, ov4}, 4'b0001);

      // back-to-back captures
      a4 = 4'h0; b4 = 4'h0;
      step();
      chk("b2b_0_q", oq4, 4'hF);
      chk("b2b_0_v", {3'b0, ov4}, 4'b0001);
      a4 = 4'hF; b4 = 4'h0;
      step();
      chk("b2b_1_q", oq4, 4'h0);
      chk("b2b_1_v", {3'b0, ov4}, 4'b0001);
      a4 = 4'h0; b4 = 4'hF;
      step();
      chk("b2b_2_q", oq4, 4'h0);
      chk("b2b_2_v", {3'b0, ov4}, 4'b0001);
      iv4 = 1'b0;
      step();
      chk("b2b_end_v", {3'b0, ov4}, 4'b0000);

`ifdef MUX_NOR_REDUCE_EN
      a4 = 4'b0000; b4 = 4'b0000; iv4 = 1'b1;
      #1;
      chk("nor_all_00", {3'b0, na4}, 4'b0001);
      step();
      iv4 = 1'b0;
      chk("nor_all_q_00", {3'b0, naq4}, 4'b0001);
      a4 = 4'b0010; #1;
      chk("nor_all_0010", {3'b0, na4}, 4'b0000);
      step();
      chk("nor_all_q_hold", {3'b0, naq4}, 4'b0001);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
